uart_rx: RTL

Parametrised UART receiver: next generation of the fixed 8N1 LED-receiver. It supports configurable baud divisor and data width, optional parity checking, start-bit glitch rejection and stop-bit framing checks. Received words leave through a one-cycle valid strobe rather than static LED bits. It sits between the board RX pin and any downstream consumer (LED register, FIFO, command decoder).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver FSM state type
package uart_pkg;

    localparam int UART_BAUD_DIV_DEFAULT  = 5208;
    localparam int UART_DATA_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RX pin synchroniser with falling-edge detector
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx_uart      raw asynchronous serial line, idle high
//   rx_sync      line after two synchroniser flops (ff2)
//   start_edge   high while ff2 == 0 and ff3 == 1 (synchronised 1->0 edge)
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_uart,
    output logic rx_sync,
    output logic start_edge
);

    logic ff1;
    logic ff2;
    logic ff3;

    // Reset to the idle level so releasing reset on an idle line never
    // looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= 1'b1;
            ff2 <= 1'b1;
            ff3 <= 1'b1;
        end else begin
            ff1 <= rx_uart;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign rx_sync    = ff2;
    assign start_edge = ~ff2 & ff3;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - parametrised UART receiver with glitch reject and framing checks
// Build option: UART_RX_PARITY_EN adds a parity bit after the data bits.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx_uart      asynchronous serial input, idle high, LSB first
//   rx_data      last good word; held until the next good frame
//   rx_valid     one-cycle pulse, rx_data is new and error-free
//   frame_err    one-cycle pulse, stop bit sampled 0
//   parity_err   one-cycle pulse, parity mismatch (constant 0 without parity)
//   busy         high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
    parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_uart,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 par_bad, par_bad_n;
    logic                 valid_n, ferr_n, perr_n;
    logic                 rx_sync, start_edge;
    logic                 half_tick, bit_tick, last_bit, par_exp;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_uart    (rx_uart),
        .rx_sync    (rx_sync),
        .start_edge (start_edge)
    );

    assign half_tick = (cnt == CNT_W'(BAUD_DIV / 2 - 1));
    assign bit_tick  = (cnt == CNT_W'(BAUD_DIV - 1));
    assign last_bit  = (idx == IDX_W'(DATA_BITS - 1));
    // Odd parity expects the inverse of the XOR of the data bits.
    assign par_exp   = (^shift) ^ PARITY_ODD;
    assign busy      = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        idx_n     = idx;
        shift_n   = shift;
        par_bad_n = par_bad;
        data_n    = rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start_edge) begin
                    state_n = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (half_tick) begin
                    cnt_n     = '0;
                    idx_n     = '0;
                    par_bad_n = 1'b0;
                    state_n   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_sync;
                    if (last_bit) begin
                        state_n = PAR_EN ? PARITY : STOP;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    cnt_n     = '0;
                    par_bad_n = (rx_sync != par_exp);
                    state_n   = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rx_sync) begin
                        ferr_n = 1'b1;
                    end else if (PAR_EN && par_bad) begin
                        perr_n = 1'b1;
                    end else begin
                        data_n  = shift;
                        valid_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            par_bad    <= par_bad_n;
            rx_data    <= data_n;
            rx_valid   <= valid_n;
            frame_err  <= ferr_n;
            parity_err <= perr_n;
        end
    end

endmodule
